// File: rtl/pcpi_ctrl_window_pkg.sv
// Shared estimator constants: instruction decode, result sentinels and FSM state encoding.
package estimator_pkg;

  localparam logic [6:0]  EST_OPCODE   = 7'h27;
  localparam logic [2:0]  F3_LOAD      = 3'd0;
  localparam logic [2:0]  F3_SETDS     = 3'd1;
  localparam logic [2:0]  F3_CALC      = 3'd2;

  localparam logic [31:0] EST_MASK     = 32'hfe00_707f;
  localparam logic [31:0] MATCH_LOAD   = 32'h0000_0027;
  localparam logic [31:0] MATCH_SETDS  = 32'h0000_1027;
  localparam logic [31:0] MATCH_CALC   = 32'h0000_2027;

  localparam logic [31:0] RD_NOT_READY = 32'h8000_0000;
  localparam logic [31:0] RD_TIMEOUT   = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_SETDS  = 2'd1,
    OP_NOTRDY = 2'd2
  } op_t;

endpackage

// File: rtl/pcpi_ctrl_window_if.sv
// PCPI port plus estimator datapath handshake; slave is the control-window block.
interface pcpi_ctrl_window_if #(
  parameter int N = 8,
  parameter int K = 512
);
  logic           pcpi_valid;
  logic [31:0]    pcpi_insn;
  logic [31:0]    pcpi_rs1;
  logic [31:0]    pcpi_rs2;
  logic           pcpi_wr;
  logic [31:0]    pcpi_rd;
  logic           pcpi_wait;
  logic           pcpi_ready;
  logic [K*N-1:0] win_data;
  logic           calc_start;
  logic           calc_done;
  logic [31:0]    calc_result;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, calc_done, calc_result,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, win_data, calc_start
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, calc_done, calc_result,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, win_data, calc_start
  );
endinterface

// File: rtl/pcpi_ctrl_window_shift.sv
// K x N control-vector window; each load shifts in one 32-bit word as P = 32/N vectors.
module ctrl_window_shift #(
  parameter int N = 8,
  parameter int K = 512
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_load_en,
  input  logic [31:0]    i_word,
  output logic [K*N-1:0] o_win
);
  localparam int P = 32 / N;

  logic [K*N-1:0] r_win;
  logic [31:0]    w_group;

  // Top slice of the word lands in vector 0 (newest); bottom slice is the oldest of the group.
  always_comb begin
    w_group = '0;
    for (int j = 0; j < P; j++) begin
      w_group[j*N +: N] = i_word[(P-1-j)*N +: N];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_win <= '0;
    end else if (i_load_en) begin
      r_win <= {r_win[(K-P)*N-1:0], w_group};
    end
  end

  assign o_win = r_win;

endmodule

// File: rtl/pcpi_ctrl_window.sv
// PCPI front-end for the estimator: decode, control window, downsample gating, datapath launch.
// Optional watchdog in WAIT enabled by defining CTRL_WINDOW_TIMEOUT_EN.
module pcpi_ctrl_window
  import estimator_pkg::*;
#(
  parameter int N       = 8,
  parameter int K       = 512,
  parameter int DS_W    = 8,
  parameter int TIMEOUT = 1024
) (
  input logic                clk,
  input logic                resetn,
  pcpi_ctrl_window_if.slave  bus
);
  localparam int              P       = 32 / N;
  localparam int              CW      = DS_W + 7;
  localparam logic [DS_W-1:0] CNT_MAX = '1;

  if ((32 % N) != 0 || (K % P) != 0 || TIMEOUT < 1) begin : g_param_chk
    $error("pcpi_ctrl_window: illegal N/K/TIMEOUT combination");
  end

  state_t          r_state;
  op_t             r_op;
  logic [DS_W-1:0] r_ds;
  logic [DS_W-1:0] r_new_cnt;
  logic [31:0]     r_rd;
  logic            r_wr;
  logic            r_calc_start;

  logic [31:0]     w_masked;
  logic            w_is_load, w_is_setds, w_is_calc, w_claim;
  logic            w_cnt_ready, w_load_en, w_tmo_hit;
  logic [CW-1:0]   w_cnt_sum;
  logic [DS_W-1:0] w_cnt_inc, w_ds_new;
  logic            w_unused;

  assign w_unused   = ^bus.pcpi_rs2;

  assign w_masked   = bus.pcpi_insn & EST_MASK;
  assign w_is_load  = (w_masked == MATCH_LOAD);
  assign w_is_setds = (w_masked == MATCH_SETDS);
  assign w_is_calc  = (w_masked == MATCH_CALC);
  assign w_claim    = w_is_load | w_is_setds | w_is_calc;

  assign w_cnt_ready = (r_new_cnt >= r_ds);
  assign w_cnt_sum   = CW'(r_new_cnt) + CW'(P);
  assign w_cnt_inc   = (w_cnt_sum > CW'(CNT_MAX)) ? CNT_MAX : w_cnt_sum[DS_W-1:0];
  assign w_ds_new    = (bus.pcpi_rs1[DS_W-1:0] == '0) ? DS_W'(1) : bus.pcpi_rs1[DS_W-1:0];

  // Window only moves in EXEC, so it is naturally frozen across START..RESP.
  assign w_load_en = (r_state == ST_EXEC) && bus.pcpi_valid && (r_op == OP_LOAD);

  ctrl_window_shift #(
    .N (N),
    .K (K)
  ) u_shift (
    .clk       (clk),
    .resetn    (resetn),
    .i_load_en (w_load_en),
    .i_word    (bus.pcpi_rs1),
    .o_win     (bus.win_data)
  );

`ifdef CTRL_WINDOW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (!resetn || r_state != ST_WAIT) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_tmo_hit = (r_state == ST_WAIT) && (r_tmo == TW'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_LOAD;
      r_ds         <= DS_W'(1);
      r_new_cnt    <= '0;
      r_rd         <= '0;
      r_wr         <= 1'b0;
      r_calc_start <= 1'b0;
    end else begin
      r_calc_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.pcpi_valid && w_claim) begin
            if (w_is_calc && w_cnt_ready) begin
              r_state <= ST_START;
            end else begin
              r_state <= ST_EXEC;
              r_op    <= w_is_load ? OP_LOAD : (w_is_setds ? OP_SETDS : OP_NOTRDY);
            end
          end
        end
        ST_EXEC: begin
          if (!bus.pcpi_valid) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
            r_wr    <= 1'b0;
            r_rd    <= '0;
            case (r_op)
              OP_LOAD:  r_new_cnt <= w_cnt_inc;
              OP_SETDS: begin
                r_ds      <= w_ds_new;
                r_new_cnt <= '0;
              end
              default: begin
                r_wr <= 1'b1;
                r_rd <= RD_NOT_READY;
              end
            endcase
          end
        end
        ST_START: begin
          if (!bus.pcpi_valid) begin
            r_state <= ST_IDLE;
          end else begin
            r_state      <= ST_WAIT;
            r_calc_start <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!bus.pcpi_valid) begin
            r_state <= ST_IDLE;
          end else if (bus.calc_done) begin
            r_state   <= ST_RESP;
            r_wr      <= 1'b1;
            r_rd      <= bus.calc_result;
            r_new_cnt <= w_cnt_ready ? (r_new_cnt - r_ds) : '0;
          end else if (w_tmo_hit) begin
            r_state <= ST_RESP;
            r_wr    <= 1'b1;
            r_rd    <= RD_TIMEOUT;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pcpi_wait  = (r_state != ST_IDLE);
  assign bus.pcpi_ready = (r_state == ST_RESP);
  assign bus.pcpi_wr    = (r_state == ST_RESP) && r_wr;
  assign bus.pcpi_rd    = (r_state == ST_RESP) ? r_rd : '0;
  assign bus.calc_start = r_calc_start;

endmodule

// File: tb/tb_pcpi_ctrl_window.sv
// Directed bench for pcpi_ctrl_window: PCPI instruction sequences with a scripted datapath.
module tb_pcpi_ctrl_window;
  localparam int N = 8;
  localparam int K = 512;

  localparam logic [31:0] I_LOAD  = 32'h0005_02A7;
  localparam logic [31:0] I_SETDS = 32'h0005_12A7;
  localparam logic [31:0] I_CALC  = 32'h0005_22A7;
  localparam logic [31:0] I_BAD3  = 32'h0005_32A7;
  localparam logic [31:0] I_BADF7 = 32'h0205_22A7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pcpi_ctrl_window_if #(.N(N), .K(K)) bus ();

  pcpi_ctrl_window #(
    .N(N), .K(K), .DS_W(8), .TIMEOUT(1024)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction; if dp_delay >= 0 the datapath answers dp_delay cycles after calc_start.
  task automatic exec(input logic [31:0] insn, input logic [31:0] rs1, input int dp_delay,
                      input logic [31:0] dp_res, output logic [31:0] rd, output logic wr,
                      output int lat, output int nstart, output logic side_ok);
    int cyc;
    int st;
    cyc = 0; st = -1; rd = '0; wr = 1'b0; lat = -1; nstart = 0; side_ok = 1'b1;
    @(negedge clk);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = 32'hFFFF_FFFF;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.calc_done = 1'b0;
      if (bus.calc_start) begin
        nstart++;
        st = cyc;
      end
      if (st >= 0 && dp_delay >= 0 && cyc == st + dp_delay) begin
        bus.calc_done   = 1'b1;
        bus.calc_result = dp_res;
      end
      if (bus.pcpi_ready) begin
        rd  = bus.pcpi_rd;
        wr  = bus.pcpi_wr;
        lat = cyc;
        break;
      end
      if (!bus.pcpi_wait || bus.pcpi_wr || bus.pcpi_rd != 0) side_ok = 1'b0;
    end
    bus.pcpi_valid = 1'b0;
    bus.calc_done  = 1'b0;
    @(negedge clk);
    if (bus.pcpi_ready || bus.pcpi_wr || bus.pcpi_rd != 0) side_ok = 1'b0;
  endtask

  logic [31:0] rd;
  logic        wr, ok, seen, quiet;
  int          lat, ns;
  logic [31:0] word;

  initial begin
    bus.pcpi_valid  = 1'b0;
    bus.pcpi_insn   = '0;
    bus.pcpi_rs1    = '0;
    bus.pcpi_rs2    = '0;
    bus.calc_done   = 1'b0;
    bus.calc_result = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.pcpi_ready, 1'b0);
    chk("rst_wait", bus.pcpi_wait, 1'b0);
    chk("rst_wr_rd", {bus.pcpi_wr, bus.pcpi_rd}, 33'h0);
    chk("rst_start", bus.calc_start, 1'b0);
    chk("rst_win", |bus.win_data, 1'b0);
    resetn = 1'b1;

    // First LOAD: vector 0 = rs1[31:24], vector 3 = rs1[7:0]
    exec(I_LOAD, 32'h0403_0201, -1, '0, rd, wr, lat, ns, ok);
    chk("load_lat", lat, 2);
    chk("load_wr", wr, 1'b0);
    chk("load_side", ok, 1'b1);
    chk("load_win_lo", bus.win_data[31:0], 32'h0102_0304);
    chk("load_win_hi", |bus.win_data[K*N-1:32], 1'b0);

    // ds=1 after reset, new_cnt=4: calculation launches
    exec(I_CALC, '0, 3, 32'h0000_55AA, rd, wr, lat, ns, ok);
    chk("ds1_calc_starts", ns, 1);
    chk("ds1_calc_rd", rd, 32'h0000_55AA);
    chk("ds1_calc_lat", lat, 6);

    // SETDS 16 then four LOADs -> exactly enough for one calculation
    exec(I_SETDS, 32'd16, -1, '0, rd, wr, lat, ns, ok);
    chk("setds_lat", lat, 2);
    chk("setds_wr", wr, 1'b0);
    for (int i = 0; i < 4; i++) exec(I_LOAD, 32'h1111_1111 * (i + 1), -1, '0, rd, wr, lat, ns, ok);
    exec(I_CALC, '0, 5, 32'h0000_1234, rd, wr, lat, ns, ok);
    chk("calc16_starts", ns, 1);
    chk("calc16_rd", rd, 32'h0000_1234);
    chk("calc16_wr", wr, 1'b1);
    chk("calc16_lat", lat, 8);
    chk("calc16_side", ok, 1'b1);

    // new_cnt now 0 -> sentinel
    exec(I_CALC, '0, 2, 32'h0BAD_0BAD, rd, wr, lat, ns, ok);
    chk("cnt0_nostart", ns, 0);
    chk("cnt0_rd", rd, 32'h8000_0000);
    chk("cnt0_wr", wr, 1'b1);
    chk("cnt0_lat", lat, 2);

    // One LOAD (4 < 16) -> still sentinel
    exec(I_LOAD, 32'hCAFE_F00D, -1, '0, rd, wr, lat, ns, ok);
    exec(I_CALC, '0, 2, 32'h0BAD_0BAD, rd, wr, lat, ns, ok);
    chk("cnt4_nostart", ns, 0);
    chk("cnt4_rd", rd, 32'h8000_0000);

    // SETDS 0 is stored as 1 and clears new_cnt
    exec(I_SETDS, 32'h0000_0F00, -1, '0, rd, wr, lat, ns, ok);
    exec(I_CALC, '0, 2, 32'h0BAD_0BAD, rd, wr, lat, ns, ok);
    chk("ds0_cleared_rd", rd, 32'h8000_0000);
    exec(I_LOAD, 32'h0000_0000, -1, '0, rd, wr, lat, ns, ok);
    exec(I_CALC, '0, 0, 32'h0000_0042, rd, wr, lat, ns, ok);
    chk("ds0_as1_starts", ns, 1);
    chk("ds0_as1_rd", rd, 32'h0000_0042);

    // Unclaimed encodings never wait or complete
    quiet = 1'b1;
    @(negedge clk);
    bus.pcpi_valid = 1'b1; bus.pcpi_insn = I_BAD3;
    repeat (4) begin @(negedge clk); if (bus.pcpi_wait || bus.pcpi_ready) quiet = 1'b0; end
    bus.pcpi_insn = I_BADF7;
    repeat (4) begin @(negedge clk); if (bus.pcpi_wait || bus.pcpi_ready) quiet = 1'b0; end
    bus.pcpi_valid = 1'b0;
    chk("unclaimed_quiet", quiet, 1'b1);

    // 129 distinct words into a 512-deep window, with new_cnt saturating at 255
    exec(I_SETDS, 32'd255, -1, '0, rd, wr, lat, ns, ok);
    for (int i = 1; i <= K/4 + 1; i++) begin
      word = {8'(i), 8'(i + 64), 8'(i + 128), 8'(i + 192)};
      exec(I_LOAD, word, -1, '0, rd, wr, lat, ns, ok);
    end
    chk("win_v0", bus.win_data[7:0], 8'h81);
    chk("win_v3", bus.win_data[31:24], 8'h41);
    chk("win_top", bus.win_data[K*N-1 -: 8], 8'hC2);
    chk("win_km4", bus.win_data[(K-4)*N +: 8], 8'h02);
    exec(I_CALC, '0, 1, 32'hDEAD_BEEF, rd, wr, lat, ns, ok);
    chk("sat_starts", ns, 1);
    chk("sat_rd", rd, 32'hDEAD_BEEF);
    exec(I_CALC, '0, 1, 32'h0BAD_0BAD, rd, wr, lat, ns, ok);
    chk("sat_after_rd", rd, 32'h8000_0000);

    // pcpi_valid dropped in WAIT: abort, stray calc_done ignored, new_cnt kept
    exec(I_SETDS, 32'd1, -1, '0, rd, wr, lat, ns, ok);
    exec(I_LOAD, 32'h1234_5678, -1, '0, rd, wr, lat, ns, ok);
    @(negedge clk);
    bus.pcpi_valid = 1'b1; bus.pcpi_insn = I_CALC; bus.pcpi_rs1 = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = bus.calc_start; end
    chk("trap_start_seen", seen, 1'b1);
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    bus.calc_done = 1'b1; bus.calc_result = 32'h0000_0999;
    @(negedge clk);
    bus.calc_done = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.pcpi_ready || bus.pcpi_wait || bus.pcpi_wr || bus.pcpi_rd != 0) quiet = 1'b0;
    end
    chk("trap_quiet", quiet, 1'b1);
    exec(I_CALC, '0, 2, 32'h0000_0777, rd, wr, lat, ns, ok);
    chk("trap_cnt_kept", ns, 1);
    chk("trap_next_rd", rd, 32'h0000_0777);

    // Reset during WAIT with a stale ds of 8
    exec(I_SETDS, 32'd8, -1, '0, rd, wr, lat, ns, ok);
    exec(I_LOAD, 32'hAAAA_AAAA, -1, '0, rd, wr, lat, ns, ok);
    exec(I_LOAD, 32'h5555_5555, -1, '0, rd, wr, lat, ns, ok);
    @(negedge clk);
    bus.pcpi_valid = 1'b1; bus.pcpi_insn = I_CALC; bus.pcpi_rs1 = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = bus.calc_start; end
    chk("rstw_start_seen", seen, 1'b1);
    resetn = 1'b0; bus.pcpi_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1; bus.calc_done = 1'b1; bus.calc_result = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.calc_done = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.pcpi_ready || bus.pcpi_wait || bus.pcpi_wr || bus.pcpi_rd != 0 || bus.calc_start)
        quiet = 1'b0;
    end
    chk("rstw_quiet", quiet, 1'b1);
    chk("rstw_win", |bus.win_data, 1'b0);
    exec(I_CALC, '0, 2, 32'h0BAD_0BAD, rd, wr, lat, ns, ok);
    chk("rstw_cnt0_rd", rd, 32'h8000_0000);
    exec(I_LOAD, 32'h0102_0304, -1, '0, rd, wr, lat, ns, ok);
    exec(I_CALC, '0, 2, 32'h0000_0321, rd, wr, lat, ns, ok);
    chk("rstw_ds1_starts", ns, 1);
    chk("rstw_ds1_rd", rd, 32'h0000_0321);

    // Slow datapath: watchdog fires at 1024 WAIT cycles, otherwise WAIT holds
    exec(I_LOAD, 32'h0F0F_0F0F, -1, '0, rd, wr, lat, ns, ok);
    exec(I_CALC, '0, 1100, 32'h0000_ABCD, rd, wr, lat, ns, ok);
    chk("slow_starts", ns, 1);
`ifdef CTRL_WINDOW_TIMEOUT_EN
    chk("slow_rd", rd, 32'h7FFF_FFFF);
    chk("slow_lat", lat, 1026);
`else
    chk("slow_rd", rd, 32'h0000_ABCD);
    chk("slow_lat", lat, 1103);
`endif
    chk("slow_wr", wr, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
